systolic_output_collector: RTL
==============================

# systolic_output_collector

Receives the column-skewed partial sums leaving the bottom of `Systolic_array` and realigns them into one row-aligned result vector per input vector. Results are buffered in a small FIFO and delivered downstream over a valid/ready handshake. The block sits between the array's `partial_sum_flat` bus and the result writeback path. It is the receiving end of the array output, mirroring the skewed activation feed on the input side.

## Interface
- `SYSTOLIC_SIZE`, default 8: array dimension N, which is also the number of columns.
- `WEIGHT_WIDTH`, default 8: weight bit width.
- `ACTIVATION_WIDTH`, default 8: activation bit width.
- `PARTIAL_SUM_WIDTH`, default `WEIGHT_WIDTH+ACTIVATION_WIDTH+$clog2(SYSTOLIC_SIZE)`: per-column width (PSW).
- `FIFO_DEPTH`, default 4: result FIFO entries; must be a power of 2 and at least 2.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `flush`, in, 1: synchronous clear of all in-flight and buffered data.
- `ps_valid_in`, in, 1: column 0 of `partial_sum_flat` holds a valid sample this cycle.
- `partial_sum_flat`, in, N*PSW: array output; column j occupies bits `[j*PSW +: PSW]`.
- `out_valid`, out, 1: `out_data` holds a realigned vector.
- `out_ready`, in, 1: downstream accepts the vector.
- `out_data`, out, N*PSW: aligned vector, using the same column packing as the input.
- `fifo_count`, out, `$clog2(FIFO_DEPTH)+1`: number of occupied FIFO entries.
- `overflow`, out, 1: sticky flag; set when a vector was dropped.

## Operation
**Skew contract**
- If `ps_valid_in` is high in cycle t, column j's sample for the same vector is present on the bus in cycle t+j.
- The array cannot be stalled. There is no backpressure toward the array.

**Deskew**
- Column j passes through a delay line of N-1-j registers.
- Column N-1 has zero delay.
- `ps_valid_in` passes through a valid pipe of N-1 registers.
- All columns of vector t emerge aligned in cycle t+N-1, together with the delayed valid.
- Delay registers shift every cycle, with no enable.
- A new vector may start every cycle. Back-to-back `ps_valid_in` at full rate is supported.

**FIFO write**
- The aligned vector is written at the end of the cycle in which the delayed valid is high.
- When the FIFO is full and no pop occurs that cycle, the vector is dropped, `overflow` is set, and FIFO contents are unchanged.
- When the FIFO is full and a pop occurs in the same cycle, the write is accepted and `overflow` is not set.

**FIFO read**
- `out_valid` equals `fifo_count != 0`.
- `out_data` is the head entry, or 0 when the FIFO is empty.
- A pop happens when `out_valid && out_ready`.
- Once asserted, `out_valid` stays high until popped. `out_data` is stable while `out_valid && !out_ready`.

**Flush**
- In the flush cycle, the valid pipe, FIFO pointers, `fifo_count` and `overflow` are cleared.
- A `ps_valid_in` or pop in the flush cycle is ignored.
- Vectors whose column 0 arrived before the flush are lost.

**Arithmetic**
- Data is passed through bit-exact. There is no accumulation, sign extension or saturation.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `fifo_count`=0, `overflow`=0. Delay registers, valid pipe and FIFO storage are all 0.
- Reset asserted mid-operation discards everything immediately and asynchronously. The first valid input after release is handled normally.
- **Latency:**
  - `ps_valid_in` in cycle t with an empty FIFO gives `out_valid`=1 in cycle t+N.
  - For N=1, this is cycle t+1: no delay registers, only the FIFO write.
- **Throughput:** one vector per cycle in and out when `out_ready` is held high. `fifo_count` then never exceeds 1.
- `overflow` rises in the cycle after the dropping write. It clears only by `rst` or `flush`.
- `fifo_count` updates at the clock edge: +1 on write only, -1 on pop only, unchanged on both or neither.

## Structure
- Shared package `strait_pkg`: the PSW derivation function, the FIFO pointer width function, and the column-slice helper.
- Sub-module `ps_delay_line`, parameterised by `DEPTH` and `WIDTH`:
  - instantiated once per column in a generate loop;
  - `DEPTH`=0 degenerates to a wire.
- The FIFO is implemented inline: storage array, read and write pointers of `$clog2(FIFO_DEPTH)` bits that wrap modulo the depth, plus the count register.

## Test plan
All scenarios use N=4 and PSW=18.
- **Single vector:** `ps_valid_in` at cycle 10 with columns 0..3 = 0x11, 0x22, 0x33, 0x44 driven at cycles 10..13, and `out_ready`=1. Expect `out_valid` at cycle 14 only, `out_data`={0x44,0x33,0x22,0x11}, and `fifo_count` returning to 0.
- **Full-rate stream:** 16 consecutive vectors with column j of vector k = k*16+j, `out_ready`=1. Expect 16 outputs on consecutive cycles, in order, each correctly aligned, with no `overflow`.
- **Backpressure and overflow:** `out_ready`=0 and 5 vectors in. Expect `fifo_count`=4 and `overflow`=1 one cycle after the 5th write. Then `out_ready`=1; expect vectors 1..4 popped and vector 5 absent.
- **Full with simultaneous pop and write:** FIFO full, `out_ready` pulsed exactly in the write cycle. Expect the write accepted, `fifo_count` staying at 4, and `overflow`=0.
- **Flush in flight:** `ps_valid_in` at cycle 20, `flush` at cycle 22. Expect no `out_valid`, and `fifo_count`=0. A new vector at cycle 30 gives `out_valid` at cycle 34.
- **Asynchronous reset:** `rst` pulsed between clock edges while the FIFO holds 2 entries. Expect all outputs at reset values before the next edge.

Source files
------------

// File: rtl/systolic_output_collector_pkg.sv
// strait_pkg: shared width derivations and column packing helpers for the systolic output path
package strait_pkg;
  function automatic int psw_of(input int ww, input int aw, input int n);
    return ww + aw + $clog2(n);
  endfunction
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int col_lsb(input int j, input int w);
    return j * w;
  endfunction
endpackage

// File: rtl/systolic_output_collector_ps_delay_line.sv
// ps_delay_line: fixed-length free-running shift register, a plain wire when DEPTH is 0
module ps_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_reg
    logic [WIDTH-1:0] sr [DEPTH];
    // shift every cycle so column timing never depends on downstream state
    always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/systolic_output_collector.sv
// systolic_output_collector: deskews array column outputs into aligned vectors and buffers them in a FIFO
module systolic_output_collector import strait_pkg::*; #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = psw_of(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush,
  input  logic                                       ps_valid_in,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_flat,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] out_data,
  output logic [$clog2(FIFO_DEPTH):0]                fifo_count,
  output logic                                       overflow
);
  localparam int N   = SYSTOLIC_SIZE;
  localparam int PSW = PARTIAL_SUM_WIDTH;
  localparam int PW  = ptr_w(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  logic [N*PSW-1:0] aligned;
  logic             valid_al;
  for (genvar j = 0; j < N; j++) begin : g_col
    ps_delay_line #(.DEPTH(N - 1 - j), .WIDTH(PSW)) u_dl (
      .clk (clk),
      .rst (rst),
      .d   (partial_sum_flat[col_lsb(j, PSW) +: PSW]),
      .q   (aligned[col_lsb(j, PSW) +: PSW])
    );
  end
  if (N > 1) begin : g_vp
    logic [N-2:0] vp;
    // valid travels alongside column 0 so it lines up with the last column
    always_ff @(posedge clk or posedge rst)
      if (rst) vp <= '0;
      else if (flush) vp <= '0;
      else vp <= (N-1)'({vp, ps_valid_in});
    assign valid_al = vp[N-2];
  end else begin : g_vn
    assign valid_al = ps_valid_in;
  end
  logic [N*PSW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, full, wr_en, drop;
  // a full FIFO still takes the write when the head is popped the same cycle
  always_comb begin
    push  = valid_al & ~flush;
    pop   = (count != '0) & out_ready & ~flush;
    full  = count == CW'(FIFO_DEPTH);
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;
  end
  // pointers, occupancy and the sticky drop flag; flush clears them all
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
      if (drop) overflow <= 1'b1;
    end
  // result storage, written only on accepted vectors
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    else if (wr_en) mem[wr_ptr] <= aligned;
  assign out_valid  = count != '0;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;
endmodule
